pio_edge_capture: RTL and testbench
===================================

# pio_edge_capture

Parametrised Avalon-MM input PIO with synchronisation, per-bit edge capture, interrupt masking and level interrupt output. It generalises the fixed 32-bit, data-only input port to a configurable width and edge mode, and adds capture and interrupt behaviour. It sits on the Nios II system interconnect as a slave, one instance per input bank (buttons, switches, external status lines).

## Interface
- `WIDTH`, default 32: number of input bits, 1..32; readdata bits above `WIDTH` read 0.
- `SYNC_STAGES`, default 2: synchroniser flops per bit, 2..4.
- `EDGE_MODE`, default 0: capture mode. 0 = rising, 1 = falling, 2 = any edge.

Ports:
- `clk`  in  1: system clock; all logic is in this domain.
- `reset`  in  1: asynchronous, active-high reset.
- `address`  in  2: word register select.
- `chipselect`  in  1: slave select.
- `write`  in  1: write strobe; qualified by `chipselect`.
- `writedata`  in  32: write data; bits above `WIDTH` are ignored.
- `in_port`  in  `WIDTH`: asynchronous external inputs.
- `readdata`  out  32: registered read data.
- `irq`  out  1: level interrupt, registered.

## Operation
Register map (word offsets):
- 0 DATA: RO, synchronised `in_port`. Writes are ignored.
- 1 reserved: reads 0, writes ignored.
- 2 IRQMASK: RW, `WIDTH` bits, 1 = enable.
- 3 EDGECAP: RO with write-1-to-clear. Writing 1 clears the bit; writing 0 has no effect.

Datapath and control:
- Synchroniser: `SYNC_STAGES` flops per bit produce `sync`. A `prev` register holds `sync` delayed by one cycle.
- Edge detect, per bit:
  - rising = `sync & ~prev`
  - falling = `~sync & prev`
  - any = `sync ^ prev`
- Settle counter:
  - Counts `SYNC_STAGES+1` cycles after reset deassertion.
  - Edge detection is gated off until the count completes, so levels present at reset never produce spurious captures.
- EDGECAP bit: sets on a detected edge and stays set until cleared by W1C.
  - Set and W1C in the same cycle on the same bit: set wins.
- irq: registered `|(EDGECAP & IRQMASK)`.
- readdata:
  - Registered every cycle from the address mux, regardless of `read` or `chipselect`, giving zero-wait-state reads with one-cycle registered latency.
  - Zero-extended to 32 bits.

Reset values: `readdata` = 0, `irq` = 0, IRQMASK = 0, EDGECAP = 0, synchroniser and `prev` = 0, settle counter = 0 (gating active).

Reset asserted mid-operation clears all state immediately and asynchronously. The settle period restarts on release.

## Timing
- `in_port` bit changes and is stable at edge k:
  - `sync` valid after edge k+`SYNC_STAGES`−1.
  - EDGECAP bit set at edge k+`SYNC_STAGES`.
  - `irq` high at edge k+`SYNC_STAGES`+1, if masked in.
- DATA read: `readdata` reflects `sync` sampled at the edge where `address`=0 is presented. Latency is 1 cycle from address to readdata.
- Write taking effect:
  - A write at edge m updates IRQMASK/EDGECAP at edge m.
  - `irq` reflects the write at edge m+1.
  - A read of the same register at edge m+1 returns the new value.
- Input pulses shorter than one `clk` period may be missed; this is not guaranteed capture.
- Edges arriving during the settle window are discarded, not deferred.

## Structure
- Shared package `pio_pkg`:
  - register offset constants `PIO_ADDR_DATA`=0, `PIO_ADDR_IRQMASK`=2, `PIO_ADDR_EDGECAP`=3;
  - edge mode constants `PIO_EDGE_RISE`/`PIO_EDGE_FALL`/`PIO_EDGE_ANY`.
- One sub-module, `pio_sync_chain`: parametrised `WIDTH` × `SYNC_STAGES` flop chain with async active-high reset, reused by future output/bidir PIO variants.
- Settle counter, edge logic, registers and read mux live in `pio_edge_capture`.

## Test plan
- Reset release with `in_port`=0xFFFFFFFF, `EDGE_MODE`=0 → EDGECAP reads 0 and `irq` stays 0 for 20 cycles; DATA reads 0xFFFFFFFF.
- `WIDTH`=8, rising mode, IRQMASK=0x01, `in_port` 0x00→0x81 → EDGECAP=0x81 at k+2; `irq`=1 at k+3; DATA=0x81.
- W1C 0x01 to EDGECAP → EDGECAP=0x80 and `irq`=0 next cycle; write 0x00 → EDGECAP unchanged.
- W1C of bit 0 in the same cycle as a new rising edge on bit 0 → bit 0 remains 1 and `irq` stays 1.
- `EDGE_MODE`=2, `in_port` 0x0→0x4→0x0 with gaps of 5 cycles; clear between the two edges → bit 2 sets on each edge. Falling mode sets only on 0x4→0x0.
- Reset asserted while `irq`=1 and EDGECAP=0xFF → `irq`, `readdata`, IRQMASK and EDGECAP are 0 immediately, before the next `clk` edge.

Source files
------------

// File: rtl/pio_pkg.sv
// rtl/pio_pkg.sv - shared register map and edge mode constants for the PIO family
package pio_pkg;

   localparam int PIO_DATA_W = 32;

   localparam logic [1:0] PIO_ADDR_DATA    = 2'd0;
   localparam logic [1:0] PIO_ADDR_RSVD    = 2'd1;
   localparam logic [1:0] PIO_ADDR_IRQMASK = 2'd2;
   localparam logic [1:0] PIO_ADDR_EDGECAP = 2'd3;

   localparam int PIO_EDGE_RISE = 0;
   localparam int PIO_EDGE_FALL = 1;
   localparam int PIO_EDGE_ANY  = 2;

endpackage

// File: rtl/pio_edge_capture_if.sv
// rtl/pio_edge_capture_if.sv - Avalon-MM register port shared by PIO slaves
interface pio_edge_capture_if;
   import pio_pkg::*;

   logic [1:0]            address;
   logic                  chipselect;
   logic                  write;
   logic [PIO_DATA_W-1:0] writedata;
   logic [PIO_DATA_W-1:0] readdata;

   modport master (
      output address,
      output chipselect,
      output write,
      output writedata,
      input  readdata
   );

   modport slave (
      input  address,
      input  chipselect,
      input  write,
      input  writedata,
      output readdata
   );

endinterface

// File: rtl/pio_sync_chain.sv
// rtl/pio_sync_chain.sv - WIDTH x SYNC_STAGES synchroniser flop chain
module pio_sync_chain #(
   parameter int WIDTH       = 32,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] stage [SYNC_STAGES];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < SYNC_STAGES; i++) begin
            stage[i] <= '0;
         end
      end else begin
         stage[0] <= d;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            stage[i] <= stage[i-1];
         end
      end
   end

   assign q = stage[SYNC_STAGES-1];

endmodule

// File: rtl/pio_edge_capture.sv
// rtl/pio_edge_capture.sv - input PIO with synchroniser, edge capture and masked level irq
module pio_edge_capture
   import pio_pkg::*;
#(
   parameter int WIDTH       = 32,
   parameter int SYNC_STAGES = 2,
   parameter int EDGE_MODE   = PIO_EDGE_RISE
) (
   input  logic              clk,
   input  logic              reset,
   pio_edge_capture_if.slave bus,
   input  logic [WIDTH-1:0]  in_port,
   output logic              irq
);

   localparam logic [2:0] SETTLE_DONE = 3'(SYNC_STAGES + 1);

   logic [WIDTH-1:0]      sync;
   logic [WIDTH-1:0]      prev;
   logic [WIDTH-1:0]      edge_raw;
   logic [WIDTH-1:0]      edge_hit;
   logic [WIDTH-1:0]      irq_mask;
   logic [WIDTH-1:0]      edge_cap;
   logic [WIDTH-1:0]      w1c;
   logic [2:0]            settle_cnt;
   logic                  settled;
   logic                  wr_en;
   logic [PIO_DATA_W-1:0] rd_mux;
   logic                  unused_wd;

   pio_sync_chain #(
      .WIDTH       (WIDTH),
      .SYNC_STAGES (SYNC_STAGES)
   ) u_sync (
      .clk   (clk),
      .reset (reset),
      .d     (in_port),
      .q     (sync)
   );

   // Detection stays gated until the chain and prev hold post-reset samples,
   // so levels already present at reset release never look like edges.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         settle_cnt <= '0;
         prev       <= '0;
      end else begin
         prev <= sync;
         if (!settled) begin
            settle_cnt <= settle_cnt + 3'd1;
         end
      end
   end

   assign settled = (settle_cnt == SETTLE_DONE);

   always_comb begin
      case (EDGE_MODE)
         PIO_EDGE_FALL: edge_raw = ~sync & prev;
         PIO_EDGE_ANY:  edge_raw = sync ^ prev;
         default:       edge_raw = sync & ~prev;
      endcase
   end

   assign edge_hit  = settled ? edge_raw : '0;
   assign wr_en     = bus.chipselect & bus.write;
   assign w1c       = (wr_en && bus.address == PIO_ADDR_EDGECAP) ? bus.writedata[WIDTH-1:0] : '0;
   assign unused_wd = ^bus.writedata;

   always_comb begin
      rd_mux = '0;
      case (bus.address)
         PIO_ADDR_DATA:    rd_mux[WIDTH-1:0] = sync;
         PIO_ADDR_IRQMASK: rd_mux[WIDTH-1:0] = irq_mask;
         PIO_ADDR_EDGECAP: rd_mux[WIDTH-1:0] = edge_cap;
         default:          rd_mux = '0;
      endcase
   end

   // A fresh edge on a bit being cleared in the same cycle keeps the bit set.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         irq_mask     <= '0;
         edge_cap     <= '0;
         irq          <= 1'b0;
         bus.readdata <= '0;
      end else begin
         if (wr_en && bus.address == PIO_ADDR_IRQMASK) begin
            irq_mask <= bus.writedata[WIDTH-1:0];
         end
         edge_cap     <= (edge_cap & ~w1c) | edge_hit;
         irq          <= |(edge_cap & irq_mask);
         bus.readdata <= rd_mux;
      end
   end

endmodule

// File: tb/tb_pio_edge_capture.sv
// tb/tb_pio_edge_capture.sv - directed and randomized bench for pio_edge_capture
module tb_pio_edge_capture;
   import pio_pkg::*;

   localparam int ND = 4;
   localparam int S  = 2;

   logic        clk;
   logic        reset;
   logic [1:0]  address;
   logic        chipselect;
   logic        write;
   logic [31:0] writedata;
   logic [31:0] in_port;

   logic [31:0] rd_a  [ND];
   logic        irq_a [ND];

   int checks;
   int errors;

   // Reference: in_port sample history since reset plus architectural registers.
   logic [31:0] hist [$];
   int          n_edge;
   logic [31:0] m_mask [ND];
   logic [31:0] m_cap  [ND];
   logic [31:0] m_rd   [ND];
   logic        m_irq  [ND];

   pio_edge_capture_if bus0 ();
   pio_edge_capture_if bus1 ();
   pio_edge_capture_if bus2 ();
   pio_edge_capture_if bus3 ();

   assign bus0.address = address;  assign bus0.chipselect = chipselect;
   assign bus0.write   = write;    assign bus0.writedata  = writedata;
   assign bus1.address = address;  assign bus1.chipselect = chipselect;
   assign bus1.write   = write;    assign bus1.writedata  = writedata;
   assign bus2.address = address;  assign bus2.chipselect = chipselect;
   assign bus2.write   = write;    assign bus2.writedata  = writedata;
   assign bus3.address = address;  assign bus3.chipselect = chipselect;
   assign bus3.write   = write;    assign bus3.writedata  = writedata;

   assign rd_a[0] = bus0.readdata;
   assign rd_a[1] = bus1.readdata;
   assign rd_a[2] = bus2.readdata;
   assign rd_a[3] = bus3.readdata;

   pio_edge_capture #(.WIDTH(32), .SYNC_STAGES(S), .EDGE_MODE(PIO_EDGE_RISE)) dut0 (
      .clk(clk), .reset(reset), .bus(bus0), .in_port(in_port), .irq(irq_a[0]));
   pio_edge_capture #(.WIDTH(8), .SYNC_STAGES(S), .EDGE_MODE(PIO_EDGE_RISE)) dut1 (
      .clk(clk), .reset(reset), .bus(bus1), .in_port(in_port[7:0]), .irq(irq_a[1]));
   pio_edge_capture #(.WIDTH(8), .SYNC_STAGES(S), .EDGE_MODE(PIO_EDGE_FALL)) dut2 (
      .clk(clk), .reset(reset), .bus(bus2), .in_port(in_port[7:0]), .irq(irq_a[2]));
   pio_edge_capture #(.WIDTH(8), .SYNC_STAGES(S), .EDGE_MODE(PIO_EDGE_ANY)) dut3 (
      .clk(clk), .reset(reset), .bus(bus3), .in_port(in_port[7:0]), .irq(irq_a[3]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int dut_width(int d);
      return (d == 0) ? 32 : 8;
   endfunction

   function automatic int dut_mode(int d);
      case (d)
         2:       return PIO_EDGE_FALL;
         3:       return PIO_EDGE_ANY;
         default: return PIO_EDGE_RISE;
      endcase
   endfunction

   function automatic logic [31:0] wmask(int d);
      if (dut_width(d) == 32) return 32'hFFFF_FFFF;
      return (32'h1 << dut_width(d)) - 32'h1;
   endfunction

   function automatic logic [31:0] in_at(int j);
      if (j < 1 || j >= hist.size()) return 32'h0;
      return hist[j];
   endfunction

   task automatic model_reset();
      hist.delete();
      hist.push_back(32'h0);
      n_edge = 0;
      for (int d = 0; d < ND; d++) begin
         m_mask[d] = 32'h0;
         m_cap[d]  = 32'h0;
         m_rd[d]   = 32'h0;
         m_irq[d]  = 1'b0;
      end
   endtask

   // Called once per rising clk edge with the inputs that edge samples.
   task automatic model_update();
      logic [31:0] s, p, wm, e, rd, clr;
      if (reset) begin
         model_reset();
      end else begin
         n_edge++;
         hist.push_back(in_port);
         s = in_at(n_edge - S);
         p = in_at(n_edge - S - 1);
         for (int d = 0; d < ND; d++) begin
            wm = wmask(d);
            case (dut_mode(d))
               PIO_EDGE_FALL: e = ~s & p;
               PIO_EDGE_ANY:  e = s ^ p;
               default:       e = s & ~p;
            endcase
            e = (n_edge >= S + 2) ? (e & wm) : 32'h0;
            case (address)
               PIO_ADDR_DATA:    rd = s & wm;
               PIO_ADDR_IRQMASK: rd = m_mask[d];
               PIO_ADDR_EDGECAP: rd = m_cap[d];
               default:          rd = 32'h0;
            endcase
            clr = (chipselect && write && address == PIO_ADDR_EDGECAP) ? (writedata & wm) : 32'h0;
            m_rd[d]  = rd;
            m_irq[d] = |(m_cap[d] & m_mask[d]);
            if (chipselect && write && address == PIO_ADDR_IRQMASK) m_mask[d] = writedata & wm;
            m_cap[d] = (m_cap[d] & ~clr) | e;
         end
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_update();
      @(negedge clk);
   endtask

   task automatic bus_write(input logic [1:0] a, input logic [31:0] wd);
      chipselect = 1'b1;
      write      = 1'b1;
      address    = a;
      writedata  = wd;
      step();
      chipselect = 1'b0;
      write      = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; in_port = 32'hFFFF_FFFF; chipselect = 1'b0; write = 1'b0;
      address = PIO_ADDR_EDGECAP; writedata = 32'h0;
      model_reset();
      repeat (3) step();
      reset = 1'b0;
      bus_write(PIO_ADDR_IRQMASK, 32'hFFFF_FFFF);
      address = PIO_ADDR_EDGECAP;
      for (int i = 0; i < 20; i++) begin
         step();
         for (int d = 0; d < ND; d++) begin
            checks++;
            if (rd_a[d] !== 32'h0 || irq_a[d] !== 1'b0) begin
               errors++;
               $display("FAIL reset_quiet dut%0d cyc%0d: rd=%h irq=%b, expected rd=0 irq=0", d, i, rd_a[d], irq_a[d]);
            end
            checks++;
            if (rd_a[d] !== m_rd[d] || irq_a[d] !== m_irq[d]) begin
               errors++;
               $display("FAIL model_reset dut%0d cyc%0d: rd=%h irq=%b, expected rd=%h irq=%b", d, i, rd_a[d], irq_a[d], m_rd[d], m_irq[d]);
            end
         end
      end
      address = PIO_ADDR_DATA;
      step();
      checks++;
      if (rd_a[0] !== 32'hFFFF_FFFF || rd_a[1] !== 32'h0000_00FF) begin
         errors++;
         $display("FAIL reset_data: rd0=%h rd1=%h, expected rd0=ffffffff rd1=000000ff", rd_a[0], rd_a[1]);
      end
   endtask

   task automatic test_rise();
      in_port = 32'h0;
      repeat (6) step();
      bus_write(PIO_ADDR_EDGECAP, 32'hFFFF_FFFF);
      bus_write(PIO_ADDR_IRQMASK, 32'h1);
      address = PIO_ADDR_EDGECAP;
      repeat (2) step();
      in_port = 32'h81;
      for (int i = 1; i <= 6; i++) begin
         step();
         for (int d = 0; d < ND; d++) begin
            checks++;
            if (rd_a[d] !== m_rd[d] || irq_a[d] !== m_irq[d]) begin
               errors++;
               $display("FAIL model_rise dut%0d cyc%0d: rd=%h irq=%b, expected rd=%h irq=%b", d, i, rd_a[d], irq_a[d], m_rd[d], m_irq[d]);
            end
         end
         if (i == 3) begin
            checks++;
            if (irq_a[1] !== 1'b0) begin
               errors++;
               $display("FAIL rise_irq_early: irq=%b, expected 0", irq_a[1]);
            end
         end
         if (i == 4) begin
            checks++;
            if (irq_a[1] !== 1'b1 || rd_a[1] !== 32'h81) begin
               errors++;
               $display("FAIL rise_capture: irq=%b edgecap=%h, expected irq=1 edgecap=00000081", irq_a[1], rd_a[1]);
            end
         end
      end
      address = PIO_ADDR_DATA;
      step();
      checks++;
      if (rd_a[0] !== 32'h81 || rd_a[1] !== 32'h81) begin
         errors++;
         $display("FAIL rise_data: rd0=%h rd1=%h, expected 00000081", rd_a[0], rd_a[1]);
      end
   endtask

   task automatic test_w1c();
      address = PIO_ADDR_EDGECAP;
      step();
      bus_write(PIO_ADDR_EDGECAP, 32'h1);
      step();
      checks++;
      if (rd_a[1] !== 32'h80 || irq_a[1] !== 1'b0) begin
         errors++;
         $display("FAIL w1c_clear: edgecap=%h irq=%b, expected edgecap=00000080 irq=0", rd_a[1], irq_a[1]);
      end
      bus_write(PIO_ADDR_EDGECAP, 32'h0);
      step();
      checks++;
      if (rd_a[1] !== 32'h80) begin
         errors++;
         $display("FAIL w1c_zero: edgecap=%h, expected 00000080", rd_a[1]);
      end
      for (int d = 0; d < ND; d++) begin
         checks++;
         if (rd_a[d] !== m_rd[d] || irq_a[d] !== m_irq[d]) begin
            errors++;
            $display("FAIL model_w1c dut%0d: rd=%h irq=%b, expected rd=%h irq=%b", d, rd_a[d], irq_a[d], m_rd[d], m_irq[d]);
         end
      end
   endtask

   task automatic test_set_wins();
      address = PIO_ADDR_EDGECAP;
      in_port = 32'h80;
      repeat (5) step();
      in_port = 32'h81;
      repeat (5) step();
      in_port = 32'h80;
      step();
      step();
      in_port = 32'h81;
      step();
      step();
      bus_write(PIO_ADDR_EDGECAP, 32'h1);
      address = PIO_ADDR_EDGECAP;
      for (int i = 0; i < 3; i++) begin
         step();
         checks++;
         if (irq_a[1] !== 1'b1 || rd_a[1][0] !== 1'b1) begin
            errors++;
            $display("FAIL set_wins cyc%0d: irq=%b edgecap=%h, expected irq=1 bit0=1", i, irq_a[1], rd_a[1]);
         end
         for (int d = 0; d < ND; d++) begin
            checks++;
            if (rd_a[d] !== m_rd[d] || irq_a[d] !== m_irq[d]) begin
               errors++;
               $display("FAIL model_set_wins dut%0d cyc%0d: rd=%h irq=%b, expected rd=%h irq=%b", d, i, rd_a[d], irq_a[d], m_rd[d], m_irq[d]);
            end
         end
      end
   endtask

   task automatic test_any_fall();
      in_port = 32'h0;
      repeat (6) step();
      bus_write(PIO_ADDR_EDGECAP, 32'hFFFF_FFFF);
      bus_write(PIO_ADDR_IRQMASK, 32'h4);
      address = PIO_ADDR_EDGECAP;
      in_port = 32'h4;
      repeat (5) step();
      checks++;
      if (rd_a[3][2] !== 1'b1 || rd_a[2][2] !== 1'b0) begin
         errors++;
         $display("FAIL edge_first: any=%h fall=%h, expected any bit2=1 fall bit2=0", rd_a[3], rd_a[2]);
      end
      bus_write(PIO_ADDR_EDGECAP, 32'h4);
      address = PIO_ADDR_EDGECAP;
      in_port = 32'h0;
      for (int i = 0; i < 5; i++) begin
         step();
         for (int d = 0; d < ND; d++) begin
            checks++;
            if (rd_a[d] !== m_rd[d] || irq_a[d] !== m_irq[d]) begin
               errors++;
               $display("FAIL model_any_fall dut%0d cyc%0d: rd=%h irq=%b, expected rd=%h irq=%b", d, i, rd_a[d], irq_a[d], m_rd[d], m_irq[d]);
            end
         end
      end
      checks++;
      if (rd_a[3][2] !== 1'b1 || rd_a[2][2] !== 1'b1 || rd_a[1][2] !== 1'b0) begin
         errors++;
         $display("FAIL edge_second: any=%h fall=%h rise=%h, expected bit2 1/1/0", rd_a[3], rd_a[2], rd_a[1]);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(2) == 0) in_port = $urandom();
         chipselect = 1'($urandom_range(1));
         write      = 1'($urandom_range(1));
         address    = 2'($urandom_range(3));
         writedata  = $urandom();
         step();
         for (int d = 0; d < ND; d++) begin
            checks++;
            if (rd_a[d] !== m_rd[d] || irq_a[d] !== m_irq[d]) begin
               errors++;
               $display("FAIL model_random dut%0d cyc%0d: rd=%h irq=%b, expected rd=%h irq=%b", d, i, rd_a[d], irq_a[d], m_rd[d], m_irq[d]);
            end
         end
      end
      chipselect = 1'b0;
      write      = 1'b0;
   endtask

   task automatic test_async_reset();
      in_port = 32'h0;
      repeat (6) step();
      bus_write(PIO_ADDR_EDGECAP, 32'hFFFF_FFFF);
      bus_write(PIO_ADDR_IRQMASK, 32'hFF);
      address = PIO_ADDR_EDGECAP;
      in_port = 32'hFF;
      repeat (6) step();
      checks++;
      if (rd_a[1] !== 32'hFF || irq_a[1] !== 1'b1) begin
         errors++;
         $display("FAIL pre_reset: edgecap=%h irq=%b, expected edgecap=000000ff irq=1", rd_a[1], irq_a[1]);
      end
      #2;
      reset = 1'b1;
      model_reset();
      #1;
      for (int d = 0; d < ND; d++) begin
         checks++;
         if (rd_a[d] !== 32'h0 || irq_a[d] !== 1'b0) begin
            errors++;
            $display("FAIL async_reset dut%0d: rd=%h irq=%b, expected rd=0 irq=0", d, rd_a[d], irq_a[d]);
         end
      end
      checks++;
      if (dut1.irq_mask !== 8'h0 || dut1.edge_cap !== 8'h0) begin
         errors++;
         $display("FAIL async_regs: irqmask=%h edgecap=%h, expected 00", dut1.irq_mask, dut1.edge_cap);
      end
      @(negedge clk);
      step();
      reset = 1'b0;
      for (int i = 0; i < 10; i++) begin
         step();
         for (int d = 0; d < ND; d++) begin
            checks++;
            if (rd_a[d] !== 32'h0 || irq_a[d] !== 1'b0 || rd_a[d] !== m_rd[d] || irq_a[d] !== m_irq[d]) begin
               errors++;
               $display("FAIL resettle dut%0d cyc%0d: rd=%h irq=%b, expected rd=%h irq=%b", d, i, rd_a[d], irq_a[d], m_rd[d], m_irq[d]);
            end
         end
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_rise();
      test_w1c();
      test_set_wins();
      test_any_fall();
      test_random();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
